mcd212_clut_pixel_out: RTL

//  Display-side stage downstream of the mcd212 DRAM/bus block. Buffers 16-bit video-RAM words in a FIFO.

---
 rtl/mcd212_clut_pixel_out.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/mcd212_clut_pixel_out.sv
// CLUT pixel output stage: buffers video words, unpacks two 8-bit indices per word and emits CLUT RGB pixels.
// Optional feature macro PIXEL_DOUBLE_EN adds double_en, which emits every index on two consecutive strobes.
module mcd212_clut_pixel_out #(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned LINE_PIXELS = 384
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        line_start,
    output logic        fetch_req,
    input  logic        fetch_ack,
    input  logic [15:0] fetch_data,
    input  logic        pix_strobe,
    output logic        pix_valid,
    output logic [17:0] pix_rgb,
    output logic        underrun,
    output logic        line_done,
    input  logic        clut_we,
    input  logic [7:0]  clut_addr,
    input  logic [17:0] clut_wdata
`ifdef PIXEL_DOUBLE_EN
    ,
    input  logic        double_en
`endif
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PIX_W = $clog2(LINE_PIXELS + 1);
    localparam int unsigned WL_W  = $clog2(LINE_PIXELS / 2 + 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t           state_q, state_d;
    logic [15:0]      fifo_mem [FIFO_DEPTH];
    logic [17:0]      clut [256];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WL_W-1:0]  words_left_q, words_left_d;
    logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;
    logic             byte_sel_q, byte_sel_d;
    logic             rep_q, rep_d;
    logic             dbl_q, dbl_d;
    logic             fetch_req_d, pix_valid_d, underrun_d, line_done_d;
    logic [17:0]      pix_rgb_d;
    logic             push, pop, dbl_in;
    logic [15:0]      head;
    logic [7:0]       index;

`ifdef PIXEL_DOUBLE_EN
    assign dbl_in = double_en;
`else
    assign dbl_in = 1'b0;
`endif

    // Next-state, FIFO bookkeeping and pixel selection
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        words_left_d = words_left_q;
        pix_cnt_d    = pix_cnt_q;
        byte_sel_d   = byte_sel_q;
        rep_d        = rep_q;
        dbl_d        = dbl_q;
        underrun_d   = underrun;
        pix_valid_d  = 1'b0;
        pix_rgb_d    = '0;
        line_done_d  = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;
        head         = fifo_mem[rd_ptr_q];
        index        = '0;

        if (line_start) begin
            state_d      = ACTIVE;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            pix_cnt_d    = '0;
            byte_sel_d   = 1'b0;
            rep_d        = 1'b0;
            dbl_d        = dbl_in;
            underrun_d   = 1'b0;
            words_left_d = dbl_in ? WL_W'(LINE_PIXELS / 4) : WL_W'(LINE_PIXELS / 2);
        end else if (state_q == ACTIVE) begin
            push = fetch_req && fetch_ack;
            if (push) begin
                wr_ptr_d     = wr_ptr_q + PTR_W'(1);
                words_left_d = words_left_q - WL_W'(1);
            end
            if (pix_strobe) begin
                pix_valid_d = 1'b1;
                pix_cnt_d   = pix_cnt_q + PIX_W'(1);
                if (count_q == '0) begin
                    underrun_d = 1'b1;
                end else begin
                    index     = byte_sel_q ? head[7:0] : head[15:8];
                    pix_rgb_d = clut[index];
                    if (dbl_q && !rep_q) begin
                        rep_d = 1'b1;
                    end else begin
                        rep_d      = 1'b0;
                        byte_sel_d = !byte_sel_q;
                        if (byte_sel_q) begin
                            pop      = 1'b1;
                            rd_ptr_d = rd_ptr_q + PTR_W'(1);
                        end
                    end
                end
                if (pix_cnt_q == PIX_W'(LINE_PIXELS - 1)) begin
                    state_d     = IDLE;
                    line_done_d = 1'b1;
                end
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        // Request is evaluated on the post-update state so the FIFO keeps a free slot for the ack in flight
        fetch_req_d = (state_d == ACTIVE) && (words_left_d != '0) &&
                      (count_d <= CNT_W'(FIFO_DEPTH - 2));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            words_left_q <= '0;
            pix_cnt_q    <= '0;
            byte_sel_q   <= 1'b0;
            rep_q        <= 1'b0;
            dbl_q        <= 1'b0;
            fetch_req    <= 1'b0;
            pix_valid    <= 1'b0;
            pix_rgb      <= '0;
            underrun     <= 1'b0;
            line_done    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            words_left_q <= words_left_d;
            pix_cnt_q    <= pix_cnt_d;
            byte_sel_q   <= byte_sel_d;
            rep_q        <= rep_d;
            dbl_q        <= dbl_d;
            fetch_req    <= fetch_req_d;
            pix_valid    <= pix_valid_d;
            pix_rgb      <= pix_rgb_d;
            underrun     <= underrun_d;
            line_done    <= line_done_d;
        end
    end

    // Storage arrays carry no reset; CLUT contents survive reset
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= fetch_data;
        end
    end

    always_ff @(posedge clk) begin
        if (clut_we) begin
            clut[clut_addr] <= clut_wdata;
        end
    end

endmodule
